// File: rtl/display_scan.sv
// display_scan: time-multiplexed 4-digit segment driver fed from snapshot shadow registers.
// Optional macro BLANK_GAP_EN blanks the first BLANK_CYC cycles of every slot (anti-ghosting).
module display_scan #(
   parameter int N_out = 7,
   parameter int PRESCALE = 50000,
   parameter int BLANK_CYC = 2,
   parameter logic [N_out-1:0] SEG_OFF = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_out-1:0] D_un,
   input  logic [N_out-1:0] D_de,
   input  logic [N_out-1:0] D_ce,
   input  logic [N_out-1:0] D_mi,
   output logic [N_out-1:0] seg_out,
   output logic [3:0]       dig_n,
   output logic             frame_tick
);
   localparam int CW = $clog2(PRESCALE);
   logic [CW-1:0]    cnt;
   logic [1:0]       idx;
   logic             loaded;
   logic [N_out-1:0] sh [4];
   logic             wrap, snap, act;
   always_comb begin
      wrap = en && loaded && cnt == CW'(PRESCALE - 1);
      snap = en && (!loaded || (wrap && idx == 2'd3));
`ifdef BLANK_GAP_EN
      act  = en && loaded && cnt >= CW'(BLANK_CYC);
`else
      act  = en && loaded;
`endif
   end
   // The first snapshot after reset only arms the scan; cnt/idx start moving on the next cycle.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt        <= '0;
         idx        <= '0;
         loaded     <= 1'b0;
         sh         <= '{default: SEG_OFF};
         seg_out    <= SEG_OFF;
         dig_n      <= 4'hF;
         frame_tick <= 1'b0;
      end else begin
         if (en && loaded) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) idx <= idx + 1'b1;
         end
         if (snap) begin
            loaded <= 1'b1;
            sh     <= '{D_un, D_de, D_ce, D_mi};
         end
         frame_tick <= snap;
         seg_out    <= act ? sh[idx] : SEG_OFF;
         dig_n      <= act ? ~(4'b0001 << idx) : 4'hF;
      end
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed scoreboard bench for display_scan (PRESCALE=4, BLANK_CYC=1).
// Expectations follow BLANK_GAP_EN so the same bench covers both builds.
module tb_display_scan;
`ifdef BLANK_GAP_EN
   localparam bit GAP = 1'b1;
`else
   localparam bit GAP = 1'b0;
`endif
   logic       clk = 1'b0, rst_n = 1'b1, en = 1'b0;
   logic [6:0] d_un = '0, d_de = '0, d_ce = '0, d_mi = '0;
   logic [6:0] seg_out;
   logic [3:0] dig_n;
   logic       frame_tick;
   logic [11:0] q[$];
   int total = 0, bad = 0;

   display_scan #(.N_out(7), .PRESCALE(4), .BLANK_CYC(1)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .D_un(d_un), .D_de(d_de), .D_ce(d_ce), .D_mi(d_mi),
      .seg_out(seg_out), .dig_n(dig_n), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, logic [11:0] got, logic [11:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h (dig_n,seg_out,frame_tick)", name, got, req);
      end
   endfunction

   // Monitor: output is presented every cycle; compare whatever the stimulus queued.
   always @(posedge clk) begin : mon
      logic [11:0] e;
      #1;
      check("one_hot_low", {11'd0, $countones(~dig_n) <= 1}, 12'd1);
      if (q.size() != 0) begin
         e = q.pop_front();
         check("scan_out", {dig_n, seg_out, frame_tick}, e);
      end
   end

   task automatic push(input logic [3:0] dig, input logic [6:0] seg, input logic tick);
      q.push_back({dig, seg, tick});
      @(negedge clk);
   endtask

   task automatic cyc(input int k, input logic [6:0] v, input int c, input logic tick);
      logic [3:0] d;
      d = ~(4'b0001 << k);
      if (GAP && c < 1) push(4'hF, 7'h7F, tick);
      else push(d, v, tick);
   endtask

   task automatic slot(input int k, input logic [6:0] v, input logic last);
      for (int c = 0; c < 4; c++) cyc(k, v, c, last && c == 3);
   endtask

   task automatic frame(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c, input logic [6:0] d);
      slot(0, a, 1'b0);
      slot(1, b, 1'b0);
      slot(2, c, 1'b0);
      slot(3, d, 1'b1);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1 check("reset_async", {dig_n, seg_out, frame_tick}, {4'hF, 7'h7F, 1'b0});
      d_un = 7'h40; d_de = 7'h79; d_ce = 7'h24; d_mi = 7'h30;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      en = 1'b1;
      push(4'hF, 7'h7F, 1'b1);
      frame(7'h40, 7'h79, 7'h24, 7'h30);
      slot(0, 7'h40, 1'b0);
      d_de = 7'h5B;
      slot(1, 7'h79, 1'b0);
      d_un = 7'h12;
      slot(2, 7'h24, 1'b0);
      slot(3, 7'h30, 1'b1);
      frame(7'h12, 7'h5B, 7'h24, 7'h30);
      slot(0, 7'h12, 1'b0);
      cyc(1, 7'h5B, 0, 1'b0);
      cyc(1, 7'h5B, 1, 1'b0);
      en = 1'b0;
      repeat (5) push(4'hF, 7'h7F, 1'b0);
      en = 1'b1;
      cyc(1, 7'h5B, 2, 1'b0);
      cyc(1, 7'h5B, 3, 1'b0);
      slot(2, 7'h24, 1'b0);
      slot(3, 7'h30, 1'b1);
      slot(0, 7'h12, 1'b0);
      cyc(1, 7'h5B, 0, 1'b0);
      cyc(1, 7'h5B, 1, 1'b0);
      #2 rst_n = 1'b0;
      #1 check("reset_mid", {dig_n, seg_out, frame_tick}, {4'hF, 7'h7F, 1'b0});
      en = 1'b0;
      d_un = 7'h01; d_de = 7'h02; d_ce = 7'h04; d_mi = 7'h08;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) push(4'hF, 7'h7F, 1'b0);
      en = 1'b1;
      push(4'hF, 7'h7F, 1'b1);
      frame(7'h01, 7'h02, 7'h04, 7'h08);
      #2 check("queue_drained", 12'(q.size()), 12'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 The block SHALL take parameter N_out, default 7, as the segment pattern width.
REQ-002 The block SHALL take parameter PRESCALE, default 50000, as the clock cycles per digit slot; legal values are 2 and above.
REQ-003 The block SHALL take parameter BLANK_CYC, default 2, as the dead-time cycles at slot start; legal values are 1 to PRESCALE-1.
REQ-004 The block SHALL take parameter SEG_OFF, default all ones (7'h7F), as the segment pattern driven while blanked.
REQ-005 clk  input  1  single system clock, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 en  input  1  scan enable; high = run.
REQ-008 D_un, D_de, D_ce, D_mi  input  N_out each  segment patterns for units, tens, hundreds and thousands digits.
REQ-009 seg_out  output  N_out  shared segment bus.
REQ-010 dig_n  output  4  active-low digit enables; bit0 = units through bit3 = thousands.
REQ-011 frame_tick  output  1  one-cycle pulse when a new input snapshot is taken.

Function
REQ-012 Slot counter cnt SHALL count 0 to PRESCALE-1 while en=1 and loaded=1; on reaching PRESCALE-1 it SHALL wrap to 0 and advance idx in the order 0,1,2,3,0.
REQ-013 Four shadow registers SHALL hold the displayed patterns; the live inputs SHALL never reach seg_out directly.
REQ-014 Snapshot, normal case: on a cycle with en=1, loaded=1, cnt=PRESCALE-1 and idx=3, the shadows SHALL load all four inputs, and frame_tick SHALL be 1 on the following cycle.
REQ-015 Snapshot, first after reset: while loaded=0, the first cycle with en=1 SHALL load the shadows, set loaded, and pulse frame_tick; cnt and idx SHALL NOT advance on that cycle.
REQ-016 seg_out, dig_n and frame_tick SHALL be registered, so at cycle t+1 they reflect the state at cycle t.
REQ-017 Active drive: in slot idx=k, dig_n SHALL have only bit k low, and seg_out SHALL equal shadow k.
REQ-018 Blanking: dig_n SHALL be 4'b1111 and seg_out SHALL be SEG_OFF whenever en=0 or loaded=0.
REQ-019 When en=0, cnt and idx SHALL hold; when en returns to 1, the scan SHALL resume from the held cnt and idx.
REQ-020 No cycle SHALL ever have more than one dig_n bit low.
REQ-021 Input changes between snapshots SHALL have no effect on the outputs until the next snapshot.

Reset
REQ-022 While rst_n=0, without waiting for a clock edge:
- cnt=0, idx=0, loaded=0
- all shadows = SEG_OFF
- seg_out = SEG_OFF, dig_n = 4'b1111, frame_tick = 0
REQ-023 Reset asserted mid-frame SHALL abandon the frame; after release, the next snapshot SHALL follow REQ-015.

Configuration
REQ-024 With macro BLANK_GAP_EN defined, for cnt in 0 to BLANK_CYC-1 of every slot:
- dig_n SHALL be 4'b1111 and seg_out SHALL be SEG_OFF (anti-ghosting dead time)
- the active drive of REQ-017 SHALL apply for cnt in BLANK_CYC to PRESCALE-1
REQ-025 With BLANK_GAP_EN undefined, the active drive SHALL apply for the whole slot, and BLANK_CYC SHALL be ignored.

Verification (PRESCALE=4, BLANK_CYC=1, N_out=7)
REQ-026 Scenario 1, basic scan:
- Stimulus: reset; en=1; D_un=7'h40, D_de=7'h79, D_ce=7'h24, D_mi=7'h30; BLANK_GAP_EN undefined.
- Response: dig_n cycles 1110, 1101, 1011, 0111, 4 cycles each, with seg_out 40, 79, 24, 30; frame_tick pulses every 16 cycles.
REQ-027 Scenario 2, input change mid-frame:
- Stimulus: change D_un to 7'h12 during the idx=2 slot.
- Response: seg_out stays 7'h40 in the units slot until after the next frame_tick, then shows 7'h12.
REQ-028 Scenario 3, enable drop:
- Stimulus: en=0 at cnt=1 of the idx=1 slot for 5 cycles.
- Response: next cycle dig_n=1111 and seg_out=7'h7F; after en=1, slot 1 resumes with 2 remaining cycles; no frame_tick during the pause.
REQ-029 Scenario 4, reset mid-frame:
- Stimulus: rst_n low mid-slot, between clock edges.
- Response: dig_n=1111 and seg_out=7'h7F immediately; after release, the first en cycle pulses frame_tick.
REQ-030 Scenario 5, dead time:
- Stimulus: BLANK_GAP_EN defined, data as in scenario 1.
- Response: each slot shows 1 cycle of dig_n=1111 with 7'h7F, then 3 cycles active; the one-hot-low check of REQ-020 holds on every cycle.
